// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage RISC-V pipeline: drives a single-outstanding data-memory
// bus, sizes/aligns store data and extracts loads for write-back.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [2:0]  mem_func3,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write_en,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_mem_to_reg_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic        mem_fault,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write_en
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [31:0] ld_q;
  logic [1:0]  off;
  logic        access;
  logic        bad_access;

  function automatic logic func3_legal(input logic is_load, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return is_load;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  a,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign off    = mem_alu_result[1:0];
  assign access = mem_mem_read ^ mem_mem_write;

  // Read+write together is never a legal access; it faults rather than going to the bus.
  assign bad_access = (mem_mem_read & mem_mem_write)
                    | (access & (~func3_legal(mem_mem_read, mem_func3) | misaligned(mem_func3, off)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ld_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: if (access && !bad_access) state <= BUSY;
        BUSY: if (dmem_ready) begin
          state <= DONE;
          if (mem_mem_read) ld_q <= dmem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus signals come straight from the frozen EX-MEM inputs, so they hold through BUSY.
  always_comb begin
    dmem_wstrb = 4'b0000;
    case (mem_func3[1:0])
      2'b00:   dmem_wdata = {4{mem_rs2_data[7:0]}};
      2'b01:   dmem_wdata = {2{mem_rs2_data[15:0]}};
      default: dmem_wdata = mem_rs2_data;
    endcase
    if (mem_mem_write) begin
      case (mem_func3[1:0])
        2'b00:   dmem_wstrb = 4'b0001 << off;
        2'b01:   dmem_wstrb = off[1] ? 4'b1100 : 4'b0011;
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

  assign dmem_req  = (state == BUSY);
  assign dmem_we   = mem_mem_write;
  assign dmem_addr = {mem_alu_result[31:2], 2'b00};

  assign mem_fault = (state == IDLE) && bad_access;
  assign stall_req = ((state == IDLE) && access && !bad_access) || (state == BUSY);

  always_comb begin
    case (mem_mem_to_reg_sel)
      2'b00:   wb_data = mem_alu_result;
      2'b01:   wb_data = load_extract(ld_q, off, mem_func3);
      2'b10:   wb_data = mem_pc_plus_4;
      default: wb_data = 32'h0;
    endcase
  end

  assign wb_rd_addr      = mem_rd_addr;
  assign wb_reg_write_en = mem_reg_write_en & ~stall_req & ~mem_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a cycle-position model of each instruction
// predicts every output, checked on each falling edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_alu_result, mem_rs2_data, mem_pc_plus_4;
  logic [2:0]  mem_func3;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write_en, mem_mem_read, mem_mem_write;
  logic [1:0]  mem_mem_to_reg_sel;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        stall_req, mem_fault, wb_reg_write_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;

  int total = 0;
  int bad   = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_fault, exp_wen, exp_we;
  logic [31:0] exp_wb, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_rd;
  logic [31:0] m_ld = 32'h0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_func3(mem_func3), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write_en(mem_reg_write_en), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg_sel(mem_mem_to_reg_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_req(stall_req), .mem_fault(mem_fault),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_reg_write_en(wb_reg_write_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes, 0 for an undefined func3.
  function automatic int m_size(input logic is_load, input logic [2:0] f3);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return is_load ? 1 : 0;
      3'd5:    return is_load ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr);
    int sz;
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    sz = m_size(rd, f3);
    if (sz == 0) return 1'b1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                         input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v | 32'hFFFFFF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v | 32'hFFFF0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    if (f3 == 3'd0) return (rs2 & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [31:0] addr, input logic [2:0] f3,
                                         input logic wr);
    if (!wr) return 4'h0;
    if (f3 == 3'd0) return 4'(32'h1 << (addr % 4));
    if (f3 == 3'd1) return 4'(32'h3 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wb(input logic [1:0] sel, input logic [31:0] alu,
                                       input logic [31:0] pc4, input logic [31:0] ld);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc4;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_req", stall_req, exp_stall);
      check("dmem_req", dmem_req, exp_req);
      check("mem_fault", mem_fault, exp_fault);
      check("wb_reg_write_en", wb_reg_write_en, exp_wen);
      check("wb_rd_addr", wb_rd_addr, exp_rd);
      if (!exp_fault) check("wb_data", wb_data, exp_wb);
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_we", dmem_we, exp_we);
        check("dmem_wstrb", dmem_wstrb, exp_wstrb);
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  // One instruction from IDLE to completion; waits = BUSY cycles with ready low.
  task automatic run(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                     input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                     input logic [4:0] rd, input logic we_i, input logic [1:0] sel,
                     input logic [31:0] rdata, input int waits,
                     input bit lit_en, input logic [31:0] lit);
    bit f, goes;
    int last;
    mem_mem_read = rd_i;  mem_mem_write = wr_i;  mem_func3 = f3;
    mem_alu_result = alu; mem_rs2_data = rs2;    mem_pc_plus_4 = pc4;
    mem_rd_addr = rd;     mem_reg_write_en = we_i; mem_mem_to_reg_sel = sel;
    f    = m_fault(rd_i, wr_i, f3, alu);
    goes = (rd_i ^ wr_i) && !f;
    last = goes ? waits + 2 : 0;
    for (int k = 0; k <= last; k++) begin
      if (goes) begin
        dmem_ready = (k == 0) || (k == waits + 1) || (k == last);
        dmem_rdata = (k == waits + 1) ? rdata : ~rdata;
        if (k == last && rd_i) m_ld = rdata;
        exp_stall = (k <= waits + 1);
        exp_req   = (k >= 1) && (k <= waits + 1);
        exp_fault = 1'b0;
        exp_wen   = we_i && (k == last);
      end else begin
        dmem_ready = 1'b1;
        dmem_rdata = ~rdata;
        exp_stall  = 1'b0;
        exp_req    = 1'b0;
        exp_fault  = f;
        exp_wen    = we_i && !f;
      end
      exp_wb    = m_wb(sel, alu, pc4, m_load(m_ld, alu, f3));
      exp_rd    = rd;
      exp_addr  = alu & 32'hFFFFFFFC;
      exp_we    = wr_i;
      exp_wdata = m_wdata(rs2, f3);
      exp_wstrb = m_wstrb(alu, f3, wr_i);
      @(negedge clk);
      if (k == last && lit_en) check("wb_literal", wb_data, lit);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_alu_result = 32'h0; mem_rs2_data = 32'h0; mem_pc_plus_4 = 32'h0;
    mem_func3 = 3'd0; mem_rd_addr = 5'd0; mem_reg_write_en = 1'b0;
    mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_mem_to_reg_sel = 2'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;

    // Model pins against hand-computed values
    check("pin_lb",  m_load(32'h80FF1234, 32'h103, 3'd0), 32'hFFFFFF80);
    check("pin_lbu", m_load(32'h80FF1234, 32'h103, 3'd4), 32'h00000080);
    check("pin_lh",  m_load(32'h80FF1234, 32'h102, 3'd1), 32'hFFFF80FF);
    check("pin_sh_wdata", m_wdata(32'h0000ABCD, 3'd1), 32'hABCDABCD);
    check("pin_sh_wstrb", m_wstrb(32'h202, 3'd1, 1'b1), 32'hC);
    check("pin_sb_wdata", m_wdata(32'h0000005A, 3'd0), 32'h5A5A5A5A);
    check("pin_sb_wstrb", m_wstrb(32'h201, 3'd0, 1'b1), 32'h2);
    check("pin_lw_fault", m_fault(1'b1, 1'b0, 3'd2, 32'h101), 32'h1);

    @(negedge clk);
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_wen", wb_reg_write_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    //  rd    wr    f3    alu           rs2           pc4       rd    we    sel   rdata         w  lit
    run(1'b1, 1'b0, 3'd2, 32'h00000100, 32'h0,        32'h104,  5'd5, 1'b1, 2'd1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
    run(1'b1, 1'b0, 3'd0, 32'h00000103, 32'h0,        32'h108,  5'd6, 1'b1, 2'd1, 32'h80FF1234, 0, 1, 32'hFFFFFF80);
    run(1'b1, 1'b0, 3'd4, 32'h00000103, 32'h0,        32'h10C,  5'd7, 1'b1, 2'd1, 32'h80FF1234, 0, 1, 32'h00000080);
    run(1'b1, 1'b0, 3'd1, 32'h00000102, 32'h0,        32'h110,  5'd8, 1'b1, 2'd1, 32'h80FF1234, 0, 1, 32'hFFFF80FF);
    run(1'b1, 1'b0, 3'd5, 32'h00000102, 32'h0,        32'h114,  5'd9, 1'b1, 2'd1, 32'h80FF1234, 1, 1, 32'h000080FF);
    run(1'b0, 1'b1, 3'd1, 32'h00000202, 32'h0000ABCD, 32'h118,  5'd0, 1'b0, 2'd0, 32'h0,        0, 0, 32'h0);
    run(1'b0, 1'b1, 3'd0, 32'h00000201, 32'h0000005A, 32'h11C,  5'd0, 1'b0, 2'd0, 32'h0,        2, 0, 32'h0);
    run(1'b0, 1'b1, 3'd2, 32'h00000204, 32'h12345678, 32'h120,  5'd0, 1'b0, 2'd0, 32'h0,        0, 0, 32'h0);
    run(1'b1, 1'b0, 3'd2, 32'h00000101, 32'h0,        32'h124,  5'd3, 1'b1, 2'd1, 32'h11111111, 0, 0, 32'h0);
    run(1'b1, 1'b0, 3'd3, 32'h00000100, 32'h0,        32'h128,  5'd4, 1'b1, 2'd1, 32'h22222222, 0, 0, 32'h0);
    run(1'b1, 1'b1, 3'd2, 32'h00000100, 32'h0,        32'h12C,  5'd4, 1'b1, 2'd0, 32'h33333333, 0, 0, 32'h0);
    run(1'b0, 1'b1, 3'd4, 32'h00000100, 32'h0,        32'h130,  5'd0, 1'b0, 2'd0, 32'h0,        0, 0, 32'h0);
    run(1'b0, 1'b1, 3'd1, 32'h00000203, 32'h0,        32'h134,  5'd0, 1'b0, 2'd0, 32'h0,        0, 0, 32'h0);
    run(1'b1, 1'b0, 3'd2, 32'h00000108, 32'h0,        32'h138,  5'd10,1'b1, 2'd1, 32'hCAFEF00D, 3, 1, 32'hCAFEF00D);
    run(1'b0, 1'b0, 3'd0, 32'h00001234, 32'h0,        32'h13C,  5'd11,1'b1, 2'd0, 32'h0,        0, 1, 32'h00001234);
    run(1'b0, 1'b0, 3'd0, 32'h00000500, 32'h0,        32'h00000040, 5'd1, 1'b1, 2'd2, 32'h0,    0, 1, 32'h00000040);
    run(1'b1, 1'b0, 3'd0, 32'h00000100, 32'h0,        32'h144,  5'd12,1'b1, 2'd1, 32'h0000007F, 0, 1, 32'h0000007F);

    // Abort an access mid-BUSY with an asynchronous reset pulse
    chk_en = 1'b0;
    mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_func3 = 3'd2;
    mem_alu_result = 32'h300; mem_rd_addr = 5'd13; mem_reg_write_en = 1'b1;
    mem_mem_to_reg_sel = 2'd1; dmem_ready = 1'b0; dmem_rdata = 32'h55555555;
    @(posedge clk);
    #1 check("abort_busy_req", dmem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_drop", dmem_req, 1'b0);
    check("abort_stall_idle", stall_req, 1'b1);
    check("abort_ld_cleared", wb_data, 32'h0);
    check("abort_wen", wb_reg_write_en, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_mem_read = 1'b0; mem_mem_to_reg_sel = 2'd0; mem_alu_result = 32'h777;
    dmem_ready = 1'b1;
    @(negedge clk);
    check("late_ready_req", dmem_req, 1'b0);
    check("late_ready_stall", stall_req, 1'b0);
    check("late_ready_wb", wb_data, 32'h777);
    @(posedge clk);
    #1 check("late_ready_idle", dmem_req, 1'b0);
    m_ld = 32'h0;
    chk_en = 1'b1;

    run(1'b1, 1'b0, 3'd1, 32'h00000302, 32'h0, 32'h148, 5'd14, 1'b1, 2'd1, 32'hF00D1234, 1, 1, 32'hFFFFF00D);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
